// File: rtl/riscv_pipeline_core.sv
// riscv_pipeline_core: 5-stage in-order RV32I-subset core with internal instruction memory, register file and data memory.
// Forwarding into EX, a one-cycle load-use stall, and branches/jumps resolved in EX with a 2-cycle flush.

module riscv_insmem #(
    parameter int IMEM_WORDS = 256
) (
    input  logic [$clog2(IMEM_WORDS)-1:0] i_addr,
    output logic [31:0]                   o_data
);
    logic [31:0] memfile [0:IMEM_WORDS-1];
    assign o_data = memfile[i_addr];
endmodule

module riscv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] regs [0:31];
    // write-through so an instruction in ID sees the value being retired this cycle
    assign o_rd1 = (i_we && i_wa != 5'd0 && i_wa == i_ra1) ? i_wd : regs[i_ra1];
    assign o_rd2 = (i_we && i_wa != 5'd0 && i_wa == i_ra2) ? i_wd : regs[i_ra2];
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (i_we && i_wa != 5'd0) regs[i_wa] <= i_wd;
endmodule

module riscv_dmem #(
    parameter int DMEM_WORDS = 256
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(DMEM_WORDS)-1:0] i_addr,
    input  logic [31:0]                   i_wd,
    output logic [31:0]                   o_rd
);
    logic [31:0] mem [0:DMEM_WORDS-1];
    assign o_rd = mem[i_addr];
    always_ff @(posedge clk)
        if (i_we) mem[i_addr] <= i_wd;
endmodule

module riscv_pipeline_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input logic clk,
    input logic rst
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic       we, mr, mw, br, jal, jalr, lui, asrc;
        logic [3:0] op;
    } ctrl_t;

    logic [31:0] r_pc, w_inst, r_ifid_inst, r_ifid_pc;
    logic [31:0] w_imm, w_rd1, w_rd2;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    ctrl_t       w_ctrl, r_idex_ctrl;
    logic [31:0] r_idex_pc, r_idex_a, r_idex_b, r_idex_imm;
    logic [4:0]  r_idex_rs1, r_idex_rs2, r_idex_rd;
    logic [31:0] w_fa, w_fb, w_b, w_alu, w_sra, w_res, w_target;
    logic        w_taken, w_redirect, w_stall;
    logic        r_exmem_we, r_exmem_mr, r_exmem_mw;
    logic [4:0]  r_exmem_rd, r_memwb_rd;
    logic [31:0] r_exmem_res, r_exmem_sd, w_dmem_rd, w_wb, r_memwb_data;
    logic        r_memwb_we;

    riscv_insmem #(.IMEM_WORDS(IMEM_WORDS)) insmem (
        .i_addr(r_pc[2 +: $clog2(IMEM_WORDS)]), .o_data(w_inst)
    );

    assign w_opc = r_ifid_inst[6:0];
    assign w_f3  = r_ifid_inst[14:12];
    assign w_rd  = r_ifid_inst[11:7];
    assign w_rs1 = r_ifid_inst[19:15];
    assign w_rs2 = r_ifid_inst[24:20];
    assign w_imm = (w_opc == 7'b0100011) ? {{20{r_ifid_inst[31]}}, r_ifid_inst[31:25], r_ifid_inst[11:7]} :
                   (w_opc == 7'b1100011) ? {{19{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[7],
                                            r_ifid_inst[30:25], r_ifid_inst[11:8], 1'b0} :
                   (w_opc == 7'b1101111) ? {{11{r_ifid_inst[31]}}, r_ifid_inst[31], r_ifid_inst[19:12],
                                            r_ifid_inst[20], r_ifid_inst[30:21], 1'b0} :
                   (w_opc == 7'b0110111) ? {r_ifid_inst[31:12], 12'd0} :
                                           {{20{r_ifid_inst[31]}}, r_ifid_inst[31:20]};

    always_comb begin
        w_ctrl = '0;
        case (w_opc)
            7'b0110011: begin w_ctrl.we = 1'b1; w_ctrl.op = {r_ifid_inst[30], w_f3}; end
            7'b0010011: begin
                w_ctrl.we = 1'b1;
                w_ctrl.asrc = 1'b1;
                w_ctrl.op = {(w_f3 == 3'b101) & r_ifid_inst[30], w_f3};
            end
            7'b0000011: begin w_ctrl.we = 1'b1; w_ctrl.mr = 1'b1; w_ctrl.asrc = 1'b1; end
            7'b0100011: begin w_ctrl.mw = 1'b1; w_ctrl.asrc = 1'b1; end
            7'b1100011: begin w_ctrl.br = (w_f3[2:1] == 2'b00); w_ctrl.op = {1'b0, w_f3}; end
            7'b1101111: begin w_ctrl.we = 1'b1; w_ctrl.jal = 1'b1; end
            7'b1100111: begin w_ctrl.we = 1'b1; w_ctrl.jalr = 1'b1; end
            7'b0110111: begin w_ctrl.we = 1'b1; w_ctrl.lui = 1'b1; end
            default: w_ctrl = '0;
        endcase
    end

    riscv_regfile regfile (
        .clk(clk), .rst(rst), .i_ra1(w_rs1), .i_ra2(w_rs2),
        .i_we(r_memwb_we), .i_wa(r_memwb_rd), .i_wd(r_memwb_data), .o_rd1(w_rd1), .o_rd2(w_rd2)
    );

    assign w_stall = r_idex_ctrl.mr && r_idex_rd != 5'd0 && (r_idex_rd == w_rs1 || r_idex_rd == w_rs2);

    assign w_fa = (r_exmem_we && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs1) ? r_exmem_res :
                  (r_memwb_we && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs1) ? r_memwb_data : r_idex_a;
    assign w_fb = (r_exmem_we && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs2) ? r_exmem_res :
                  (r_memwb_we && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs2) ? r_memwb_data : r_idex_b;
    assign w_b   = r_idex_ctrl.asrc ? r_idex_imm : w_fb;
    assign w_sra = $signed(w_fa) >>> w_b[4:0];
    assign w_alu = (r_idex_ctrl.op[2:0] == 3'd0) ? (r_idex_ctrl.op[3] ? w_fa - w_b : w_fa + w_b) :
                   (r_idex_ctrl.op[2:0] == 3'd1) ? w_fa << w_b[4:0] :
                   (r_idex_ctrl.op[2:0] == 3'd2) ? {31'd0, $signed(w_fa) < $signed(w_b)} :
                   (r_idex_ctrl.op[2:0] == 3'd3) ? {31'd0, w_fa < w_b} :
                   (r_idex_ctrl.op[2:0] == 3'd4) ? w_fa ^ w_b :
                   (r_idex_ctrl.op[2:0] == 3'd5) ? (r_idex_ctrl.op[3] ? w_sra : w_fa >> w_b[4:0]) :
                   (r_idex_ctrl.op[2:0] == 3'd6) ? w_fa | w_b : w_fa & w_b;
    assign w_res      = (r_idex_ctrl.jal || r_idex_ctrl.jalr) ? r_idex_pc + 32'd4 :
                        r_idex_ctrl.lui ? r_idex_imm : w_alu;
    assign w_taken    = r_idex_ctrl.br && ((w_fa == w_fb) != r_idex_ctrl.op[0]);
    assign w_redirect = w_taken || r_idex_ctrl.jal || r_idex_ctrl.jalr;
    assign w_target   = r_idex_ctrl.jalr ? ((w_fa + r_idex_imm) & ~32'd1) : r_idex_pc + r_idex_imm;

    riscv_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem (
        .clk(clk), .i_we(r_exmem_mw), .i_addr(r_exmem_res[2 +: $clog2(DMEM_WORDS)]),
        .i_wd(r_exmem_sd), .o_rd(w_dmem_rd)
    );
    assign w_wb = r_exmem_mr ? w_dmem_rd : r_exmem_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ifid_inst  <= NOP;
            r_ifid_pc    <= '0;
            r_idex_ctrl  <= '0;
            r_idex_pc    <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_idex_rs1   <= '0;
            r_idex_rs2   <= '0;
            r_idex_rd    <= '0;
            r_exmem_we   <= 1'b0;
            r_exmem_mr   <= 1'b0;
            r_exmem_mw   <= 1'b0;
            r_exmem_rd   <= '0;
            r_exmem_res  <= '0;
            r_exmem_sd   <= '0;
            r_memwb_we   <= 1'b0;
            r_memwb_rd   <= '0;
            r_memwb_data <= '0;
        end else begin
            r_pc <= w_redirect ? w_target : w_stall ? r_pc : r_pc + 32'd4;
            if (w_redirect) r_ifid_inst <= NOP;
            else if (!w_stall) begin
                r_ifid_inst <= w_inst;
                r_ifid_pc   <= r_pc;
            end
            r_idex_ctrl  <= (w_redirect || w_stall) ? '0 : w_ctrl;
            r_idex_pc    <= r_ifid_pc;
            r_idex_a     <= w_rd1;
            r_idex_b     <= w_rd2;
            r_idex_imm   <= w_imm;
            r_idex_rs1   <= w_rs1;
            r_idex_rs2   <= w_rs2;
            r_idex_rd    <= w_rd;
            r_exmem_we   <= r_idex_ctrl.we;
            r_exmem_mr   <= r_idex_ctrl.mr;
            r_exmem_mw   <= r_idex_ctrl.mw;
            r_exmem_rd   <= r_idex_rd;
            r_exmem_res  <= w_res;
            r_exmem_sd   <= w_fb;
            r_memwb_we   <= r_exmem_we;
            r_memwb_rd   <= r_exmem_rd;
            r_memwb_data <= w_wb;
        end
    end
endmodule

// File: tb/tb_riscv_pipeline_core.sv
// tb_riscv_pipeline_core: directed programs; expected register writes are queued and
// matched in order by a monitor that watches the register file for changes.
`timescale 1ns/1ps
module tb_riscv_pipeline_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    typedef struct {
        int          rd;
        logic [31:0] val;
    } ev_t;
    ev_t         exp_q[$];
    logic [31:0] snap[32];
    logic [31:0] prog[$];

    riscv_pipeline_core dut (.clk(clk), .rst(rst));

    always #1 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, want);
        end
    endtask

    task automatic ev(input int rd, input logic [31:0] val);
        ev_t e;
        e.rd = rd;
        e.val = val;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) snap[i] = dut.regfile.regs[i];
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (dut.regfile.regs[i] !== snap[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write x%0d got %h required no write", i, dut.regfile.regs[i]);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (e.rd != i || e.val !== dut.regfile.regs[i]) begin
                            errors++;
                            $display("FAIL writeback got x%0d=%h required x%0d=%h", i, dut.regfile.regs[i], e.rd, e.val);
                        end
                    end
                    snap[i] = dut.regfile.regs[i];
                end
            end
        end
    end

    task automatic run(input int cycles);
        @(negedge clk);
        #0.3 rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.insmem.memfile[i] = 32'h0000_006F;
        foreach (prog[i]) dut.insmem.memfile[i] = prog[i];
        @(negedge clk);
        #0.3 rst = 1'b0;
        repeat (cycles) @(negedge clk);
        #0.1;
        chk("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1.5;
        chk("reset_pc", dut.r_pc, 32'h0);
        chk("reset_ifid_nop", dut.r_ifid_inst, 32'h0000_0013);
        chk("reset_x1", dut.regfile.regs[1], 32'h0);

        // back-to-back forwarding
        prog = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h0000006F};
        ev(1, 32'd5); ev(2, 32'd7); ev(3, 32'd12);
        run(30);
        chk("fwd_x3", dut.regfile.regs[3], 32'd12);

        // store, load, load-use stall
        prog = '{32'hFFF00093, 32'h00102423, 32'h00802203, 32'h00120293, 32'h0000006F};
        ev(1, 32'hFFFF_FFFF); ev(4, 32'hFFFF_FFFF);
        run(30);
        chk("dmem2", dut.dmem.mem[2], 32'hFFFF_FFFF);
        chk("loaduse_x5", dut.regfile.regs[5], 32'h0);

        // taken beq flushes, not-taken bne falls through
        prog = '{32'h00300093, 32'h00108463, 32'h00900313, 32'h00400393,
                 32'h00739463, 32'h00200313, 32'h0000006F};
        ev(1, 32'd3); ev(7, 32'd4); ev(6, 32'd2);
        run(30);

        // jal link/flush, jalr with odd target
        prog = '{32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
                 32'h00C000EF, 32'h00100113, 32'h00100193, 32'h00008213,
                 32'h02D002E7, 32'h00100113, 32'h00100113, 32'h0000006F};
        ev(1, 32'h14); ev(4, 32'h14); ev(5, 32'h24);
        run(40);
        chk("jal_skip_x2", dut.regfile.regs[2], 32'h0);

        // x0 discard, lui, shifts, sub, slt, or
        prog = '{32'h00500013, 32'h00000433, 32'h123454B7, 32'h4044D513, 32'h409005B3,
                 32'h4045D613, 32'h0045D693, 32'h0095A733, 32'h00E4E7B3, 32'h0000006F};
        ev(9, 32'h12345000); ev(10, 32'h01234500); ev(11, 32'hEDCBB000);
        ev(12, 32'hFEDCBB00); ev(13, 32'h0EDCBB00); ev(14, 32'h1); ev(15, 32'h12345001);
        run(40);
        chk("x0_zero", dut.regfile.regs[0], 32'h0);
        chk("x8_zero", dut.regfile.regs[8], 32'h0);

        // asynchronous reset mid-run, then re-execution to the same state
        @(negedge clk);
        #0.3 rst = 1'b1;
        #0.5;
        chk("async_pc", dut.r_pc, 32'h0);
        chk("async_x9", dut.regfile.regs[9], 32'h0);
        chk("async_x15", dut.regfile.regs[15], 32'h0);
        ev(9, 32'h12345000); ev(10, 32'h01234500); ev(11, 32'hEDCBB000);
        ev(12, 32'hFEDCBB00); ev(13, 32'h0EDCBB00); ev(14, 32'h1); ev(15, 32'h12345001);
        @(negedge clk);
        #0.3 rst = 1'b0;
        repeat (40) @(negedge clk);
        #0.1;
        chk("rerun_pending", exp_q.size(), 0);
        chk("rerun_x10", dut.regfile.regs[10], 32'h01234500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
